// File: rtl/dmem_lane_arbiter_if.sv
// One issue lane's request/response bundle toward the shared data-memory arbiter.
// master = lane datapath side, slave = arbiter side.
interface dmem_lane_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          gnt;
   logic          stall;
   logic          rvalid;

   modport master (
      output req, we, addr, wdata,
      input  gnt, stall, rvalid
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, stall, rvalid
   );
endinterface

// File: rtl/dmem_lane_arbiter.sv
// Round-robin share of one data-memory port between two issue lanes; grant is combinational,
// load data returns RD_LAT cycles after grant; the losing lane is stalled and must hold its request.
module dmem_lane_arbiter #(
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int RD_LAT = 1,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   dmem_lane_arbiter_if.slave   l0,
   dmem_lane_arbiter_if.slave   l1,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [AW-1:0]        mem_addr,
   output logic [DW-1:0]        mem_wdata,
   input  logic [DW-1:0]        mem_rdata,
   output logic [DW-1:0]        rdata,
   output logic [CNT_W-1:0]     conflict_cnt
);

   logic              prio;
   logic              gnt0;
   logic              gnt1;
   logic [RD_LAT-1:0] tag_vld;
   logic [RD_LAT-1:0] tag_lane;
   logic [CNT_W-1:0]  cnt;

   // Grants are forced low while reset is held so nothing reaches memory during reset.
   always_comb begin
      gnt0      = reset & l0.req & (~l1.req | ~prio);
      gnt1      = reset & l1.req & (~l0.req | prio);
      mem_en    = gnt0 | gnt1;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (gnt0) begin
         mem_we    = l0.we;
         mem_addr  = l0.addr;
         mem_wdata = l0.wdata;
      end else if (gnt1) begin
         mem_we    = l1.we;
         mem_addr  = l1.addr;
         mem_wdata = l1.wdata;
      end
   end

   assign l0.gnt   = gnt0;
   assign l1.gnt   = gnt1;
   assign l0.stall = l0.req & ~gnt0;
   assign l1.stall = l1.req & ~gnt1;

   assign l0.rvalid    = tag_vld[RD_LAT-1] & ~tag_lane[RD_LAT-1];
   assign l1.rvalid    = tag_vld[RD_LAT-1] & tag_lane[RD_LAT-1];
   assign rdata        = mem_rdata;
   assign conflict_cnt = cnt;

   // Priority passes to the lane that did not just win; idle cycles leave it alone.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prio <= 1'b0;
      end else if (mem_en) begin
         prio <= gnt0;
      end
   end

   // Tag pipe mirrors the memory read latency and names the lane owed each return.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_vld  <= '0;
         tag_lane <= '0;
      end else begin
         tag_vld[0]  <= mem_en & ~mem_we;
         tag_lane[0] <= gnt1;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_vld[i]  <= tag_vld[i-1];
            tag_lane[i] <= tag_lane[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (l0.req && l1.req && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_dmem_lane_arbiter.sv
// Bench for dmem_lane_arbiter: two instances (RD_LAT=1/CNT_W=16 and RD_LAT=3/CNT_W=4)
// share one stimulus stream; expected grants and read returns are queued and checked by a monitor.
module tb_dmem_lane_arbiter;

   localparam logic [31:0] K  = 32'h5A5A_0000;
   localparam logic        LD = 1'b0;
   localparam logic        ST = 1'b1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   logic        r0, w0, r1, w1;
   logic [31:0] a0, d0, a1, d1;

   dmem_lane_arbiter_if ia0 ();
   dmem_lane_arbiter_if ia1 ();
   dmem_lane_arbiter_if ib0 ();
   dmem_lane_arbiter_if ib1 ();

   assign ia0.req = r0; assign ia0.we = w0; assign ia0.addr = a0; assign ia0.wdata = d0;
   assign ia1.req = r1; assign ia1.we = w1; assign ia1.addr = a1; assign ia1.wdata = d1;
   assign ib0.req = r0; assign ib0.we = w0; assign ib0.addr = a0; assign ib0.wdata = d0;
   assign ib1.req = r1; assign ib1.we = w1; assign ib1.addr = a1; assign ib1.wdata = d1;

   logic        ma_en, ma_we, mb_en, mb_we;
   logic [31:0] ma_addr, ma_wdata, ma_rdin, ma_rdata;
   logic [31:0] mb_addr, mb_wdata, mb_rdin, mb_rdata;
   logic [15:0] ca;
   logic [3:0]  cb;

   dmem_lane_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .l0(ia0), .l1(ia1),
      .mem_en(ma_en), .mem_we(ma_we), .mem_addr(ma_addr), .mem_wdata(ma_wdata),
      .mem_rdata(ma_rdin), .rdata(ma_rdata), .conflict_cnt(ca)
   );

   dmem_lane_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .CNT_W(4)) dut_b (
      .clk(clk), .reset(reset), .l0(ib0), .l1(ib1),
      .mem_en(mb_en), .mem_we(mb_we), .mem_addr(mb_addr), .mem_wdata(mb_wdata),
      .mem_rdata(mb_rdin), .rdata(mb_rdata), .conflict_cnt(cb)
   );

   // Memory model: read data is the load address scrambled, delayed by each instance's latency.
   logic [31:0] pa;
   logic [31:0] pb [3];
   always @(posedge clk) begin
      pa    <= ma_addr;
      pb[0] <= mb_addr;
      pb[1] <= pb[0];
      pb[2] <= pb[1];
   end
   assign ma_rdin = pa ^ K;
   assign mb_rdin = pb[2] ^ K;

   logic        obs_en    [2];
   logic        obs_we    [2];
   logic [31:0] obs_addr  [2];
   logic [31:0] obs_wdata [2];
   logic [31:0] obs_rdata [2];
   logic [1:0]  obs_gnt   [2];
   logic [1:0]  obs_stall [2];
   logic [1:0]  obs_rv    [2];
   logic [15:0] obs_cnt   [2];

   assign obs_en[0] = ma_en;       assign obs_en[1] = mb_en;
   assign obs_we[0] = ma_we;       assign obs_we[1] = mb_we;
   assign obs_addr[0] = ma_addr;   assign obs_addr[1] = mb_addr;
   assign obs_wdata[0] = ma_wdata; assign obs_wdata[1] = mb_wdata;
   assign obs_rdata[0] = ma_rdata; assign obs_rdata[1] = mb_rdata;
   assign obs_gnt[0] = {ia1.gnt, ia0.gnt};       assign obs_gnt[1] = {ib1.gnt, ib0.gnt};
   assign obs_stall[0] = {ia1.stall, ia0.stall}; assign obs_stall[1] = {ib1.stall, ib0.stall};
   assign obs_rv[0] = {ia1.rvalid, ia0.rvalid};  assign obs_rv[1] = {ib1.rvalid, ib0.rvalid};
   assign obs_cnt[0] = ca;                       assign obs_cnt[1] = {12'd0, cb};

   typedef struct packed {
      int          cyc;
      logic        lane;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  stall;
   } gnt_t;

   typedef struct packed {
      int          cyc;
      logic        lane;
      logic [31:0] data;
   } rd_t;

   gnt_t qg [2][$];
   rd_t  qr [2][$];

   function automatic string pfx(input int d);
      return (d == 0) ? "A" : "B";
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // One bus cycle of lane inputs plus the hand-computed grant (eg: 01 lane0, 10 lane1, 00 none).
   task automatic step(input logic q0, input logic e0, input logic [31:0] ad0, input logic [31:0] wd0,
                       input logic q1, input logic e1, input logic [31:0] ad1, input logic [31:0] wd1,
                       input logic [1:0] eg, input logic rd = 1'b1);
      gnt_t g;
      rd_t  r;
      @(posedge clk);
      #1;
      r0 = q0; w0 = e0; a0 = ad0; d0 = wd0;
      r1 = q1; w1 = e1; a1 = ad1; d1 = wd1;
      if (eg != 2'b00) begin
         g.cyc   = cyc;
         g.lane  = eg[1];
         g.we    = eg[1] ? e1 : e0;
         g.addr  = eg[1] ? ad1 : ad0;
         g.wdata = eg[1] ? wd1 : wd0;
         g.stall = {q1 & ~eg[1], q0 & ~eg[0]};
         qg[0].push_back(g);
         qg[1].push_back(g);
         if (!g.we && rd) begin
            r.lane = g.lane;
            r.data = g.addr ^ K;
            r.cyc  = cyc + 1;
            qr[0].push_back(r);
            r.cyc  = cyc + 3;
            qr[1].push_back(r);
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, LD, 0, 0, 0, LD, 0, 0, 2'b00);
   endtask

   task automatic chk_cnt(input logic [15:0] ea, input logic [15:0] eb);
      chk("A conflict_cnt", 64'(obs_cnt[0]), 64'(ea));
      chk("B conflict_cnt", 64'(obs_cnt[1]), 64'(eb));
   endtask

   // Monitor: every observed grant or read return consumes the oldest expectation.
   always @(negedge clk) begin : monitor
      gnt_t g;
      rd_t  r;
      if (reset === 1'b1) begin
         for (int d = 0; d < 2; d++) begin
            if (obs_en[d]) begin
               if (qg[d].size() == 0) begin
                  chk({pfx(d), " unexpected grant"}, 64'(obs_gnt[d]), 64'd0);
               end else begin
                  g = qg[d].pop_front();
                  chk({pfx(d), " grant cycle"}, 64'(cyc), 64'(g.cyc));
                  chk({pfx(d), " grant lane"}, 64'(obs_gnt[d]), g.lane ? 64'd2 : 64'd1);
                  chk({pfx(d), " mem_we"}, 64'(obs_we[d]), 64'(g.we));
                  chk({pfx(d), " mem_addr"}, 64'(obs_addr[d]), 64'(g.addr));
                  chk({pfx(d), " mem_wdata"}, 64'(obs_wdata[d]), 64'(g.wdata));
                  chk({pfx(d), " stall"}, 64'(obs_stall[d]), 64'(g.stall));
               end
            end else begin
               chk({pfx(d), " idle bus"}, 64'({obs_gnt[d], obs_we[d], obs_addr[d]}), 64'd0);
            end
            if (obs_rv[d] != 2'b00) begin
               chk({pfx(d), " rvalid both lanes"}, 64'(obs_rv[d] == 2'b11), 64'd0);
               if (qr[d].size() == 0) begin
                  chk({pfx(d), " unexpected rvalid"}, 64'(obs_rv[d]), 64'd0);
               end else begin
                  r = qr[d].pop_front();
                  chk({pfx(d), " rvalid cycle"}, 64'(cyc), 64'(r.cyc));
                  chk({pfx(d), " rvalid lane"}, 64'(obs_rv[d]), r.lane ? 64'd2 : 64'd1);
                  chk({pfx(d), " rdata"}, 64'(obs_rdata[d]), 64'(r.data));
               end
            end
         end
      end
   end

   initial begin
      reset = 1'b0;
      r0 = 1'b1; w0 = LD; a0 = 32'h40; d0 = 32'h0;
      r1 = 1'b0; w1 = LD; a1 = 32'h0;  d1 = 32'h0;

      // Held in reset with lane 0 requesting: nothing may reach memory.
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk({pfx(d), " reset mem_en"}, 64'({obs_en[d], obs_we[d]}), 64'd0);
         chk({pfx(d), " reset gnt"}, 64'(obs_gnt[d]), 64'd0);
         chk({pfx(d), " reset rvalid"}, 64'(obs_rv[d]), 64'd0);
         chk({pfx(d), " reset mem_addr"}, 64'({obs_addr[d], obs_wdata[d]}), 64'd0);
         chk({pfx(d), " reset cnt"}, 64'(obs_cnt[d]), 64'd0);
      end
      @(posedge clk);
      #1;
      r0 = 1'b0;
      reset = 1'b1;

      // Four conflicting store cycles; the loser holds its request until granted.
      step(1, ST, 32'h10, 32'h1111_0000, 1, ST, 32'h20, 32'h2222_0000, 2'b01);
      step(1, ST, 32'h14, 32'h1111_0001, 1, ST, 32'h20, 32'h2222_0000, 2'b10);
      step(1, ST, 32'h14, 32'h1111_0001, 1, ST, 32'h24, 32'h2222_0001, 2'b01);
      step(1, ST, 32'h18, 32'h1111_0002, 1, ST, 32'h24, 32'h2222_0001, 2'b10);
      idle(1);
      chk_cnt(16'd4, 16'd4);

      // Single lane-0 load.
      step(1, LD, 32'h100, 0, 0, LD, 0, 0, 2'b01);
      idle(4);

      // Back-to-back loads from both lanes, including a conflict with priority held by lane 1.
      step(1, LD, 32'h200, 0, 0, LD, 0, 0, 2'b01);
      step(0, LD, 0, 0, 1, LD, 32'h300, 0, 2'b10);
      step(1, LD, 32'h400, 0, 1, LD, 32'h500, 0, 2'b01);
      step(1, LD, 32'h404, 0, 1, LD, 32'h500, 0, 2'b10);
      step(1, LD, 32'h404, 0, 0, LD, 0, 0, 2'b01);
      idle(5);
      chk_cnt(16'd6, 16'd6);

      // Twenty conflict cycles, lane 1 holding priority at the start.
      for (int i = 0; i < 20; i++) begin
         step(1, ST, 32'h1000 + 32'((i / 2) * 4), 32'hA000 + 32'(i / 2),
              1, ST, 32'h2000 + 32'(((i + 1) / 2) * 4), 32'hB000 + 32'((i + 1) / 2),
              (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      idle(1);
      chk_cnt(16'd26, 16'd15);
      idle(2);
      chk_cnt(16'd26, 16'd15);

      // Load in flight when reset hits: its return must never appear, priority back to lane 0.
      step(1, LD, 32'h600, 0, 0, LD, 0, 0, 2'b01, 1'b0);
      @(posedge clk);
      #1;
      r0 = 1'b0;
      #1;
      reset = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk({pfx(d), " mid-reset rvalid"}, 64'(obs_rv[d]), 64'd0);
         chk({pfx(d), " mid-reset cnt"}, 64'(obs_cnt[d]), 64'd0);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      step(1, ST, 32'h700, 32'h7777, 1, ST, 32'h800, 32'h8888, 2'b01);
      step(0, ST, 0, 0, 1, ST, 32'h800, 32'h8888, 2'b10);
      idle(6);
      chk_cnt(16'd1, 16'd1);

      for (int d = 0; d < 2; d++) begin
         chk({pfx(d), " grants outstanding"}, 64'(qg[d].size()), 64'd0);
         chk({pfx(d), " reads outstanding"}, 64'(qr[d].size()), 64'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
